// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue
//   In-order packet FIFO between fetch and decode. It absorbs decode stalls so
//   that fetch can keep running. Each entry holds {pc, insn, bp}. A flush from
//   the controller empties the queue in one cycle.
//
//   Optional feature, selected by the macro FETCH_QUEUE_BYPASS_EN:
//     When the queue is empty, an offered packet is presented at deq in the
//     same cycle. If decode takes it, the packet is never written. Without the
//     macro, a packet reaches deq one cycle after it is enqueued.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   flush               discard all entries; blocks enq and deq this cycle
//   enq_valid/ready     fetch-side handshake; enq_ready depends only on state
//   enq_pc/insn/bp      offered packet
//   deq_valid/ready     decode-side handshake
//   deq_pc/insn/bp      head packet; all zero when deq_valid is low
//   count               occupied entries
//   almost_full         count >= DEPTH-1
module fetch_decode_queue #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int INSN_WIDTH = 32,
  parameter int BP_WIDTH   = 34
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     enq_valid,
  output logic                     enq_ready,
  input  logic [ADDR_WIDTH-1:0]    enq_pc,
  input  logic [INSN_WIDTH-1:0]    enq_insn,
  input  logic [BP_WIDTH-1:0]      enq_bp,
  output logic                     deq_valid,
  input  logic                     deq_ready,
  output logic [ADDR_WIDTH-1:0]    deq_pc,
  output logic [INSN_WIDTH-1:0]    deq_insn,
  output logic [BP_WIDTH-1:0]      deq_bp,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(DEPTH - 1);

  logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
  logic [INSN_WIDTH-1:0] insn_mem [DEPTH];
  logic [BP_WIDTH-1:0]   bp_mem   [DEPTH];

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] cnt;

  logic empty;
  logic mem_vld;
  logic byp_vld;
  logic byp_take;
  logic enq_fire;
  logic deq_fire;

  assign empty     = (cnt == '0);
  assign enq_ready = (cnt != FULL_CNT);
  // Flush hides the head for the whole cycle, so decode can never consume a
  // packet that belongs to the path being squashed.
  assign mem_vld   = !empty && !flush;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign byp_vld   = empty && enq_valid && !flush;
`else
  assign byp_vld   = 1'b0;
`endif

  assign byp_take  = byp_vld && deq_ready;
  assign deq_valid = mem_vld || byp_vld;
  // A bypassed packet that decode takes must not also be stored.
  assign enq_fire  = enq_valid && enq_ready && !flush && !byp_take;
  assign deq_fire  = mem_vld && deq_ready;

  assign count       = cnt;
  assign almost_full = (cnt >= AF_CNT);

  // Head selection: stored head first, then the bypassed packet, else a bubble.
  always_comb begin
    deq_pc   = '0;
    deq_insn = '0;
    deq_bp   = '0;
    if (mem_vld) begin
      deq_pc   = pc_mem[rd_ptr];
      deq_insn = insn_mem[rd_ptr];
      deq_bp   = bp_mem[rd_ptr];
    end else if (byp_vld) begin
      deq_pc   = enq_pc;
      deq_insn = enq_insn;
      deq_bp   = enq_bp;
    end
  end

  // Storage write; contents are not reset, since cnt alone defines validity.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      pc_mem[wr_ptr]   <= enq_pc;
      insn_mem[wr_ptr] <= enq_insn;
      bp_mem[wr_ptr]   <= enq_bp;
    end
  end

  // Control state; the pointers wrap through natural overflow, because DEPTH
  // is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (enq_fire) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq_fire) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({enq_fire, deq_fire})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule
